// File: rtl/mdu_tracker_pkg.sv
// Shared definitions for the M-extension tracker: alucodes, tag and writeback
// entry layouts, and default pipeline sizing.
package mdu_tracker_pkg;

   localparam int DEFAULT_LATENCY = 6;
   localparam int DEFAULT_QDEPTH  = 8;

   localparam logic [5:0] ALU_NOP    = 6'h00;
   localparam logic [5:0] ALU_MUL    = 6'h20;
   localparam logic [5:0] ALU_MULH   = 6'h21;
   localparam logic [5:0] ALU_MULHSU = 6'h22;
   localparam logic [5:0] ALU_MULHU  = 6'h23;
   localparam logic [5:0] ALU_DIV    = 6'h24;
   localparam logic [5:0] ALU_DIVU   = 6'h25;
   localparam logic [5:0] ALU_REM    = 6'h26;
   localparam logic [5:0] ALU_REMU   = 6'h27;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [5:0] alucode;
   } mdu_tag_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } mdu_wb_entry_t;

   // x0 is hardwired, so a zero read address never depends on anything.
   function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
      return (rs != 5'd0) && (rs == rd);
   endfunction

endpackage

// File: rtl/mdu_tracker_if.sv
// Decode, multi-cycle unit and writeback signals of the tracker; the tracker
// takes the slave side.
interface mdu_tracker_if;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [5:0]  issue_alucode;
   logic        issue_ready;
   logic        mc_done;
   logic [31:0] mc_result;
   logic [5:0]  done_alucode;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        stall_hazard;
   logic        wb_port_busy;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        sync_error;

   modport master (
      output issue_valid, issue_rd, issue_alucode, mc_done, mc_result,
             rs1_addr, rs2_addr, wb_port_busy,
      input  issue_ready, done_alucode, stall_hazard, wb_valid, wb_rd,
             wb_data, sync_error
   );

   modport slave (
      input  issue_valid, issue_rd, issue_alucode, mc_done, mc_result,
             rs1_addr, rs2_addr, wb_port_busy,
      output issue_ready, done_alucode, stall_hazard, wb_valid, wb_rd,
             wb_data, sync_error
   );
endinterface

// File: rtl/mdu_wb_fifo.sv
// Writeback queue of completed {rd, data}; every entry's rd is exposed so the
// tracker can detect hazards against results not yet written.
module mdu_wb_fifo
   import mdu_tracker_pkg::*;
#(
   parameter int DEPTH = DEFAULT_QDEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  mdu_wb_entry_t              push_entry,
   input  logic                       pop,
   output mdu_wb_entry_t              head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic [4:0]                 entry_rd [DEPTH],
   output logic [DEPTH-1:0]           entry_valid
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   mdu_wb_entry_t  mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           push_ok;
   logic           pop_ok;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wrap_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= wrap_inc(rd_ptr);
         if (push_ok && !pop_ok)      count <= count + CW'(1);
         else if (pop_ok && !push_ok) count <= count - CW'(1);
      end
   end

   // An entry is live when its distance from the head is below the count.
   always_comb begin
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         int off;
         off = i - int'(rd_ptr);
         if (off < 0) off = off + DEPTH;
         entry_valid[i] = (off < int'(count));
         entry_rd[i]    = mem[i].rd;
      end
   end

endmodule

// File: rtl/mdu_tracker.sv
// Tag pipeline, hazard detection, credit and writeback control for the
// multi-cycle M-extension unit.
module mdu_tracker
   import mdu_tracker_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int QDEPTH  = DEFAULT_QDEPTH
) (
   input logic         clk,
   input logic         rst,
   mdu_tracker_if.slave bus
);
   localparam int CW  = $clog2(QDEPTH + 1);
   localparam int MW  = $clog2(LATENCY + 1);
   localparam logic [MW-1:0] MASK_END = MW'(LATENCY);

   mdu_tag_t       tags [LATENCY];
   mdu_tag_t       tail;
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  fifo_count;
   logic           fifo_empty;
   logic           fifo_full;
   logic           credit;
   logic           accept;
   logic           push;
   logic           pop;
   logic           hit;
   logic [MW-1:0]  mask_cnt;
   logic           sync_error_q;
   mdu_wb_entry_t  push_entry;
   mdu_wb_entry_t  head;
   logic [4:0]     entry_rd [QDEPTH];
   logic [QDEPTH-1:0] entry_valid;

   assign tail       = tags[LATENCY-1];
   assign credit     = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(QDEPTH);
   assign accept     = bus.issue_valid && credit;
   assign push       = !rst && bus.mc_done && tail.valid && (tail.rd != 5'd0);
   assign pop        = !rst && !fifo_empty && !bus.wb_port_busy;
   assign push_entry = '{rd: tail.rd, data: bus.mc_result};

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(tags[i].valid);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) tags[i] <= '0;
      end else begin
         tags[0] <= '{valid: accept, rd: bus.issue_rd, alucode: bus.issue_alucode};
         for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
      end
   end

   // Completions of ops issued before a reset can still arrive for LATENCY
   // cycles afterwards, so the tail comparison waits out that window.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_cnt     <= '0;
         sync_error_q <= 1'b0;
      end else begin
         if (mask_cnt != MASK_END) mask_cnt <= mask_cnt + MW'(1);
         if ((mask_cnt == MASK_END) && (bus.mc_done != tail.valid))
            sync_error_q <= 1'b1;
         if (bus.issue_valid && !credit)
            sync_error_q <= 1'b1;
         if (push && fifo_full && !pop)
            sync_error_q <= 1'b1;
      end
   end

   always_comb begin
      hit = 1'b0;
      if (accept)
         hit = reg_match(bus.rs1_addr, bus.issue_rd) || reg_match(bus.rs2_addr, bus.issue_rd);
      for (int i = 0; i < LATENCY; i++) begin
         if (tags[i].valid)
            hit = hit || reg_match(bus.rs1_addr, tags[i].rd) || reg_match(bus.rs2_addr, tags[i].rd);
      end
      for (int i = 0; i < QDEPTH; i++) begin
         if (entry_valid[i])
            hit = hit || reg_match(bus.rs1_addr, entry_rd[i]) || reg_match(bus.rs2_addr, entry_rd[i]);
      end
   end

   assign bus.issue_ready  = rst || credit;
   assign bus.stall_hazard = !rst && hit;
   assign bus.done_alucode = (!rst && tail.valid) ? tail.alucode : ALU_NOP;
   assign bus.wb_valid     = pop;
   assign bus.wb_rd        = pop ? head.rd : 5'd0;
   assign bus.wb_data      = pop ? head.data : 32'd0;
   assign bus.sync_error   = !rst && sync_error_q;

   mdu_wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (pop),
      .head        (head),
      .count       (fifo_count),
      .empty       (fifo_empty),
      .full        (fifo_full),
      .entry_rd    (entry_rd),
      .entry_valid (entry_valid)
   );

endmodule

// File: tb/tb_mdu_tracker.sv
// Directed bench for mdu_tracker: a timestamped queue model predicts every
// output each cycle, and literal per-cycle expectations pin that model.
module tb_mdu_tracker;
   import mdu_tracker_pkg::*;

   localparam int LATENCY = DEFAULT_LATENCY;
   localparam int QDEPTH  = DEFAULT_QDEPTH;

   typedef enum int {PIN_READY, PIN_HAZ, PIN_DONEALU, PIN_WBV, PIN_WBRD, PIN_WBDATA, PIN_ERR} pin_e;
   typedef struct { int cyc; pin_e kind; logic [31:0] val; bit done; } pin_t;
   typedef struct { int t; logic [4:0] rd; logic [5:0] alu; } op_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; } wbent_t;
   typedef struct { int cyc; logic [31:0] res; } sched_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   pin_t   pins [$];
   op_t    mdlOps [$];
   wbent_t mdlFifo [$];
   sched_t sched [$];
   logic   mdlErr = 1'b0;
   int     sinceRst = 0;

   mdu_tracker_if bus();

   mdu_tracker #(.LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic pin(input int c, input pin_e k, input logic [31:0] v);
      pins.push_back('{cyc: c, kind: k, val: v, done: 1'b0});
   endtask

   // One cycle of inputs; also emulates the multi-cycle unit's done strobe.
   task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [5:0] alu,
                                input logic [31:0] res, input logic stray);
      bus.issue_valid   = v;
      bus.issue_rd      = rd;
      bus.issue_alucode = alu;
      bus.mc_done       = stray;
      bus.mc_result     = 32'hFFFF_FFFF;
      if (sched.size() > 0 && sched[0].cyc == cyc) begin
         bus.mc_done   = 1'b1;
         bus.mc_result = sched[0].res;
         void'(sched.pop_front());
      end
      if (v) sched.push_back('{cyc: cyc + LATENCY, res: res});
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, ALU_NOP, 32'd0, 1'b0);
   endtask

   function automatic bit hits(input logic [4:0] a, input bit acc);
      if (a == 5'd0) return 1'b0;
      if (acc && bus.issue_rd == a) return 1'b1;
      foreach (mdlOps[i]) if (mdlOps[i].rd == a) return 1'b1;
      foreach (mdlFifo[i]) if (mdlFifo[i].rd == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic modelCycle();
      bit tailValid, acc, expReady, expHaz, expWbv;
      logic [5:0] expAlu;
      logic [4:0] expRd;
      logic [31:0] expData, act;
      int occ;
      tailValid = mdlOps.size() > 0 && mdlOps[0].t == cyc - LATENCY;
      occ = mdlOps.size() + mdlFifo.size();
      acc = bus.issue_valid && (occ < QDEPTH);
      if (rst) begin
         expReady = 1'b1; expHaz = 1'b0; expWbv = 1'b0;
         expAlu = 6'd0; expRd = 5'd0; expData = 32'd0;
      end else begin
         expReady = occ < QDEPTH;
         expHaz   = hits(bus.rs1_addr, acc) || hits(bus.rs2_addr, acc);
         expAlu   = tailValid ? mdlOps[0].alu : 6'd0;
         expWbv   = mdlFifo.size() > 0 && !bus.wb_port_busy;
         expRd    = expWbv ? mdlFifo[0].rd : 5'd0;
         expData  = expWbv ? mdlFifo[0].data : 32'd0;
      end
      checkOutput("issue_ready", 32'(bus.issue_ready), 32'(expReady));
      checkOutput("stall_hazard", 32'(bus.stall_hazard), 32'(expHaz));
      checkOutput("done_alucode", 32'(bus.done_alucode), 32'(expAlu));
      checkOutput("wb_valid", 32'(bus.wb_valid), 32'(expWbv));
      checkOutput("sync_error", 32'(bus.sync_error), 32'(rst ? 1'b0 : mdlErr));
      if (rst || expWbv) begin
         checkOutput("wb_rd", 32'(bus.wb_rd), 32'(expRd));
         checkOutput("wb_data", bus.wb_data, expData);
      end
      foreach (pins[i]) begin
         if (pins[i].cyc == cyc) begin
            case (pins[i].kind)
               PIN_READY:   act = 32'(bus.issue_ready);
               PIN_HAZ:     act = 32'(bus.stall_hazard);
               PIN_DONEALU: act = 32'(bus.done_alucode);
               PIN_WBV:     act = 32'(bus.wb_valid);
               PIN_WBRD:    act = 32'(bus.wb_rd);
               PIN_WBDATA:  act = bus.wb_data;
               default:     act = 32'(bus.sync_error);
            endcase
            checkOutput({"pin ", pins[i].kind.name()}, act, pins[i].val);
            pins[i].done = 1'b1;
         end
      end
      if (rst) begin
         mdlOps.delete(); mdlFifo.delete();
         mdlErr = 1'b0; sinceRst = 0;
      end else begin
         if (expWbv) void'(mdlFifo.pop_front());
         if (tailValid) begin
            if (bus.mc_done && mdlOps[0].rd != 5'd0)
               mdlFifo.push_back('{rd: mdlOps[0].rd, data: bus.mc_result});
            void'(mdlOps.pop_front());
         end
         if (sinceRst >= LATENCY && bus.mc_done != tailValid) mdlErr = 1'b1;
         if (bus.issue_valid && !acc) mdlErr = 1'b1;
         else if (acc) mdlOps.push_back('{t: cyc, rd: bus.issue_rd, alu: bus.issue_alucode});
         sinceRst++;
      end
   endtask

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         modelCycle();
      end
   end

   initial begin
      int t0;
      bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; bus.issue_alucode = ALU_NOP;
      bus.mc_done = 1'b0; bus.mc_result = 32'd0;
      bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0; bus.wb_port_busy = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      pin(cyc, PIN_READY, 1); pin(cyc, PIN_WBV, 0); pin(cyc, PIN_DONEALU, 0);
      idle(2);
      rst = 1'b0;
      idle(3);

      $display("[TB] single op");
      bus.rs1_addr = 5'd5; t0 = cyc;
      pin(t0, PIN_HAZ, 1); pin(t0 + LATENCY, PIN_HAZ, 1);
      pin(t0 + LATENCY, PIN_DONEALU, 32'(ALU_MUL));
      pin(t0 + LATENCY + 1, PIN_WBV, 1); pin(t0 + LATENCY + 1, PIN_WBRD, 5);
      pin(t0 + LATENCY + 1, PIN_WBDATA, 32'h6);
      pin(t0 + LATENCY + 2, PIN_HAZ, 0); pin(t0 + LATENCY + 2, PIN_WBV, 0);
      applyStimulus(1'b1, 5'd5, ALU_MUL, 32'h0000_0006, 1'b0);
      idle(10);
      bus.rs1_addr = 5'd0;

      $display("[TB] back-to-back");
      t0 = cyc;
      pin(t0 + 6, PIN_DONEALU, 32'(ALU_MULH)); pin(t0 + 7, PIN_DONEALU, 32'(ALU_DIVU));
      pin(t0 + 8, PIN_DONEALU, 32'(ALU_REMU));
      pin(t0 + 7, PIN_WBRD, 1); pin(t0 + 8, PIN_WBRD, 2); pin(t0 + 9, PIN_WBRD, 3);
      pin(t0 + 9, PIN_WBDATA, 32'd33);
      applyStimulus(1'b1, 5'd1, ALU_MULH, 32'd11, 1'b0);
      applyStimulus(1'b1, 5'd2, ALU_DIVU, 32'd22, 1'b0);
      applyStimulus(1'b1, 5'd3, ALU_REMU, 32'd33, 1'b0);
      idle(10);

      $display("[TB] port contention");
      bus.wb_port_busy = 1'b1; t0 = cyc;
      pin(t0 + 7, PIN_READY, 1); pin(t0 + 8, PIN_READY, 0); pin(t0 + 10, PIN_READY, 0);
      pin(t0 + 11, PIN_READY, 1); pin(t0 + 9, PIN_WBV, 0); pin(t0 + 10, PIN_WBV, 1);
      pin(t0 + 10, PIN_WBRD, 8); pin(t0 + 17, PIN_WBRD, 15);
      pin(t0 + 17, PIN_WBDATA, 32'h1007); pin(t0 + 18, PIN_WBV, 0);
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b1, 5'(8 + k), ALU_MULHU, 32'h1000 + 32'(k), 1'b0);
      idle(2);
      bus.wb_port_busy = 1'b0;
      idle(12);

      $display("[TB] rd zero");
      t0 = cyc;
      pin(t0, PIN_HAZ, 0); pin(t0 + 6, PIN_DONEALU, 32'(ALU_DIV));
      pin(t0 + 7, PIN_WBV, 0); pin(t0 + 7, PIN_READY, 1);
      applyStimulus(1'b1, 5'd0, ALU_DIV, 32'hBAD, 1'b0);
      idle(9);

      $display("[TB] sync check");
      rst = 1'b1; idle(1); rst = 1'b0;
      t0 = cyc;
      idle(2);
      applyStimulus(1'b0, 5'd0, ALU_NOP, 32'd0, 1'b1);
      pin(t0 + 3, PIN_ERR, 0); pin(t0 + 12, PIN_ERR, 0);
      idle(9);
      t0 = cyc;
      pin(t0, PIN_ERR, 0); pin(t0 + 1, PIN_ERR, 1); pin(t0 + 5, PIN_ERR, 1);
      applyStimulus(1'b0, 5'd0, ALU_NOP, 32'd0, 1'b1);
      idle(6);

      $display("[TB] reset mid-flight");
      rst = 1'b1; idle(1); rst = 1'b0;
      bus.wb_port_busy = 1'b1; bus.rs1_addr = 5'd20; t0 = cyc;
      pin(t0 + 7, PIN_HAZ, 1); pin(t0 + 8, PIN_READY, 1); pin(t0 + 8, PIN_HAZ, 0);
      pin(t0 + 9, PIN_WBV, 0); pin(t0 + 9, PIN_READY, 1); pin(t0 + 9, PIN_HAZ, 0);
      pin(t0 + 20, PIN_ERR, 0);
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 5'(20 + k), ALU_REM, 32'h2000 + 32'(k), 1'b0);
      idle(3);
      rst = 1'b1; idle(1); rst = 1'b0;
      bus.wb_port_busy = 1'b0;
      idle(15);

      idle(3);
      foreach (pins[i]) begin
         if (!pins[i].done) begin
            vectors++; miscompares++;
            $display("[TB] FAIL pin %s never reached cycle %0d", pins[i].kind.name(), pins[i].cyc);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
